pkt_assembler: RTL and testbench



---
 rtl/pkt_assembler_pkg.sv | 32 +++
 rtl/pkt_asm_field_xtr.sv | 39 +++
 rtl/pkt_assembler.sv | 106 ++++++++++
 tb/tb_pkt_assembler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_assembler_pkg.sv
// Shared definitions for the event-to-fabric packet assembler.
//   PKT_BITS       : width of a SpiNNaker multicast packet.
//   *_LSB / *_BIT  : packet field offsets (payload, key, header, parity).
//   MC_TYPE        : header type code for multicast packets.
//   NUM_MREGS_DEF  : default number of mapper field extractors.
//   mc_pkt_t       : packed multicast packet layout, MSB first.
package pkt_assembler_pkg;

  localparam int unsigned PKT_BITS      = 72;
  localparam int unsigned EVT_BITS      = 32;
  localparam int unsigned KEY_BITS      = 32;
  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned SFT_BITS      = 6;
  localparam int unsigned NUM_MREGS_DEF = 4;

  localparam int unsigned PAYLOAD_LSB = 40;
  localparam int unsigned KEY_LSB     = 8;
  localparam int unsigned HDR_LSB     = 0;
  localparam int unsigned PARITY_BIT  = 0;

  localparam logic [1:0] MC_TYPE = 2'b00;

  typedef struct packed {
    logic [PAYLOAD_BITS-1:0] payload;   // [71:40]
    logic [KEY_BITS-1:0]     key;       // [39:8]
    logic [1:0]              mc_type;   // [7:6]
    logic [3:0]              rsvd;      // [5:2]
    logic                    pld_flag;  // [1]
    logic                    parity;    // [0]
  } mc_pkt_t;

endpackage

// File: rtl/pkt_asm_field_xtr.sv
// One mapper field extractor: masks the event, applies a signed shift and
// flags values above the inclusive limit. Purely combinational.
//   evt_data : event word
//   fld_msk  : field mask
//   fld_sft  : two's complement shift, >=0 shifts right, <0 shifts left
//   fld_lmt  : inclusive upper limit (unsigned)
//   fld_c    : extracted field
//   ovr_c    : field exceeds limit
module pkt_asm_field_xtr
  import pkt_assembler_pkg::*;
(
  input  logic [EVT_BITS-1:0] evt_data,
  input  logic [EVT_BITS-1:0] fld_msk,
  input  logic [SFT_BITS-1:0] fld_sft,
  input  logic [EVT_BITS-1:0] fld_lmt,
  output logic [EVT_BITS-1:0] fld_c,
  output logic                ovr_c
);

  logic [EVT_BITS-1:0] msk_c;
  logic [SFT_BITS-1:0] lsh_c;

  assign msk_c = evt_data & fld_msk;

  // Magnitude of a negative shift; -32 yields 32, which clears the field.
  assign lsh_c = SFT_BITS'(~fld_sft + SFT_BITS'(1));

  always_comb begin
    fld_c = '0;
    if (fld_sft[SFT_BITS-1]) begin
      fld_c = msk_c << lsh_c;
    end else begin
      fld_c = msk_c >> fld_sft[SFT_BITS-2:0];
    end
  end

  assign ovr_c = (fld_c > fld_lmt);

endmodule

// File: rtl/pkt_assembler.sv
// Event-to-fabric packet assembler: turns 32-bit events into 72-bit
// multicast packets whose key is the mapper key OR-ed with NUM_MREGS
// masked/shifted event fields. Events with any field above its limit are
// consumed without producing a packet.
// Optional: define PKT_ASM_DROP_CNT_EN to add drop_cnt_out, a saturating
// count of limit-dropped events.
//   clk, reset      : clock, synchronous active-high reset
//   mp_key_in       : base routing key
//   mp_fld_msk_in   : per-field masks
//   mp_fld_sft_in   : per-field signed shifts
//   mp_fld_lmt_in   : per-field inclusive limits
//   evt_data_in/vld_in/rdy_out : event handshake (rdy is combinational)
//   pkt_data_out/vld_out/rdy_in : packet handshake (data/vld registered)
//   drop_cnt_out    : dropped-event counter (optional)
module pkt_assembler
  import pkt_assembler_pkg::*;
#(
  parameter int unsigned NUM_MREGS = NUM_MREGS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] mp_key_in,
  input  logic [EVT_BITS-1:0] mp_fld_msk_in [NUM_MREGS],
  input  logic [SFT_BITS-1:0] mp_fld_sft_in [NUM_MREGS],
  input  logic [EVT_BITS-1:0] mp_fld_lmt_in [NUM_MREGS],
  input  logic [EVT_BITS-1:0] evt_data_in,
  input  logic                evt_vld_in,
  output logic                evt_rdy_out,
  output logic [PKT_BITS-1:0] pkt_data_out,
  output logic                pkt_vld_out,
  input  logic                pkt_rdy_in
`ifdef PKT_ASM_DROP_CNT_EN
  ,
  output logic [31:0]         drop_cnt_out
`endif
);

  logic [EVT_BITS-1:0]  fld_c [NUM_MREGS];
  logic [NUM_MREGS-1:0] ovr_c;
  logic [KEY_BITS-1:0]  key_c;
  logic                 drop_c;
  logic                 accept_c;
  logic                 load_c;
  mc_pkt_t              pkt_c;

  for (genvar i = 0; i < NUM_MREGS; i++) begin : g_xtr
    pkt_asm_field_xtr u_xtr (
      .evt_data (evt_data_in),
      .fld_msk  (mp_fld_msk_in[i]),
      .fld_sft  (mp_fld_sft_in[i]),
      .fld_lmt  (mp_fld_lmt_in[i]),
      .fld_c    (fld_c[i]),
      .ovr_c    (ovr_c[i])
    );
  end

  // Routing key: base key OR-ed with every extracted field.
  always_comb begin
    key_c = mp_key_in;
    for (int unsigned i = 0; i < NUM_MREGS; i++) begin
      key_c = key_c | fld_c[i];
    end
  end

  assign drop_c      = |ovr_c;
  assign evt_rdy_out = ~pkt_vld_out | pkt_rdy_in;
  assign accept_c    = evt_vld_in & evt_rdy_out;
  assign load_c      = accept_c & ~drop_c;

  // Packet image; parity makes the total number of ones odd.
  always_comb begin
    pkt_c          = '0;
    pkt_c.payload  = '0;
    pkt_c.key      = key_c;
    pkt_c.mc_type  = MC_TYPE;
    pkt_c.rsvd     = '0;
    pkt_c.pld_flag = 1'b0;
    pkt_c.parity   = ~^{pkt_c.payload, pkt_c.key, pkt_c.mc_type,
                        pkt_c.rsvd, pkt_c.pld_flag};
  end

  // Output register: load wins over take so back-to-back packets have no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_vld_out  <= 1'b0;
      pkt_data_out <= '0;
    end else if (load_c) begin
      pkt_vld_out  <= 1'b1;
      pkt_data_out <= pkt_c;
    end else if (pkt_rdy_in) begin
      pkt_vld_out  <= 1'b0;
    end
  end

`ifdef PKT_ASM_DROP_CNT_EN
  // Saturating count of limit-dropped events.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_out <= '0;
    end else if (accept_c && drop_c && (drop_cnt_out != 32'hFFFF_FFFF)) begin
      drop_cnt_out <= drop_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_assembler.sv
// Bench for pkt_assembler: a driver issues events and pushes expected
// packets from a reference model; a monitor pops and compares on each take.
module tb_pkt_assembler;
  import pkt_assembler_pkg::*;

  localparam int unsigned NM = NUM_MREGS_DEF;

  logic                clk_tb   = 1'b0;
  logic                reset_tb = 1'b1;
  logic [31:0]         key;
  logic [31:0]         msk [NM];
  logic [5:0]          sft [NM];
  logic [31:0]         lmt [NM];
  logic [31:0]         evt_data;
  logic                evt_vld;
  logic                evt_rdy;
  logic [PKT_BITS-1:0] pkt_data;
  logic                pkt_vld;
  logic                pkt_rdy;
`ifdef PKT_ASM_DROP_CNT_EN
  logic [31:0]         drop_cnt;
`endif

  int                  n_vec  = 0;
  int                  n_err  = 0;
  bit                  mon_en = 1'b0;
  logic [PKT_BITS-1:0] exp_q [$];
  longint              exp_drops = 0;

  always #5 clk_tb = ~clk_tb;

  pkt_assembler #(.NUM_MREGS(NM)) dut (
    .clk           (clk_tb),
    .reset         (reset_tb),
    .mp_key_in     (key),
    .mp_fld_msk_in (msk),
    .mp_fld_sft_in (sft),
    .mp_fld_lmt_in (lmt),
    .evt_data_in   (evt_data),
    .evt_vld_in    (evt_vld),
    .evt_rdy_out   (evt_rdy),
    .pkt_data_out  (pkt_data),
    .pkt_vld_out   (pkt_vld),
    .pkt_rdy_in    (pkt_rdy)
`ifdef PKT_ASM_DROP_CNT_EN
    ,
    .drop_cnt_out  (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [PKT_BITS-1:0] act,
                     input logic [PKT_BITS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference field value using integer arithmetic on the signed shift.
  function automatic logic [31:0] fld_model(input logic [31:0] e, input int i);
    longint unsigned m;
    int s;
    m = 64'(e & msk[i]);
    s = int'($signed(sft[i]));
    if (s >= 0) return 32'(m / (64'd1 << s));
    return 32'((m * (64'd1 << (-s))) % 64'h1_0000_0000);
  endfunction

  // Accepted event: push its packet, or count it as dropped.
  task automatic accept(input logic [31:0] e);
    logic [31:0]         k;
    logic [31:0]         f;
    logic [PKT_BITS-1:0] p;
    bit                  drop;
    k = key;
    drop = 1'b0;
    for (int i = 0; i < int'(NM); i++) begin
      f = fld_model(e, i);
      if (f > lmt[i]) drop = 1'b1;
      k = k | f;
    end
    if (drop) begin
      if (exp_drops < 64'hFFFF_FFFF) exp_drops++;
    end else begin
      p = {32'h0, k, 8'h00};
      p[0] = (($countones(p) % 2) == 0);
      exp_q.push_back(p);
    end
  endtask

  // mode: 0 = pkt_rdy high, 1 = random pkt_rdy, 2 = pkt_rdy low.
  task automatic send_evt(input logic [31:0] e, input int mode);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    @(posedge clk_tb); #1;
    evt_data = e;
    evt_vld  = 1'b1;
    while (!done) begin
      pkt_rdy = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk_tb); #1;
      if (evt_rdy === 1'b1) begin
        accept(e);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 100) begin
          n_vec++;
          n_err++;
          $display("FAIL evt_accept_timeout: got no acceptance expected within 100 cycles");
          evt_vld = 1'b0;
          done = 1'b1;
        end else begin
          @(posedge clk_tb); #1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk_tb); #1;
    evt_vld = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    idle();
    pkt_rdy = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk_tb); #1;
      cyc++;
    end
    chk("drain_left", PKT_BITS'(exp_q.size()), '0);
  endtask

  task automatic cfg_common();
    idle();
    key = 32'hEE00_0000;
    for (int i = 0; i < int'(NM); i++) begin
      msk[i] = 32'h0;
      sft[i] = 6'd0;
      lmt[i] = 32'hFFFF_FFFF;
    end
    msk[0] = 32'h00FF_0000; sft[0] = 6'd16;
    msk[1] = 32'h0000_00FF; sft[1] = 6'h38;  // -8
  endtask

  // Monitor: validity, readiness, hold stability and packet content.
  initial begin : monitor
    bit                  stall_prev;
    logic [PKT_BITS-1:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    wait (mon_en);
    forever begin
      @(negedge clk_tb);
      chk("pkt_vld", PKT_BITS'(pkt_vld), PKT_BITS'(exp_q.size() != 0));
      chk("evt_rdy", PKT_BITS'(evt_rdy), PKT_BITS'((exp_q.size() == 0) || pkt_rdy));
      if (stall_prev) chk("hold_data", pkt_data, stall_data);
      if (pkt_vld === 1'b1 && exp_q.size() != 0) begin
        chk("pkt_data", pkt_data, exp_q[0]);
        if (pkt_rdy && !reset_tb) void'(exp_q.pop_front());
      end
      stall_prev = (pkt_vld === 1'b1) && !pkt_rdy && !reset_tb;
      stall_data = pkt_data;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    evt_vld  = 1'b0;
    evt_data = '0;
    pkt_rdy  = 1'b0;
    key      = '0;
    for (int i = 0; i < int'(NM); i++) begin
      msk[i] = '0; sft[i] = '0; lmt[i] = '1;
    end
    repeat (3) @(posedge clk_tb);
    #1 reset_tb = 1'b0;
    @(negedge clk_tb);
    chk("rst_vld", PKT_BITS'(pkt_vld), '0);
    chk("rst_data", pkt_data, '0);
    mon_en = 1'b1;

    // 1: single event
    cfg_common();
    send_evt(32'h00AB_00CD, 0);
    drain();

    // 2: streaming with pkt_rdy high
    for (int n = 0; n < 20; n++) send_evt(32'(n), 0);
    drain();

    // 3: same stream with random backpressure
    for (int n = 0; n < 40; n++) send_evt(32'(n), 1);
    drain();

    // 4: limit filter
    cfg_common();
    lmt[0] = 32'h10;
    send_evt(32'h0011_0000, 1);
    send_evt(32'h0010_0000, 1);
    drain();
`ifdef PKT_ASM_DROP_CNT_EN
    chk("drop_cnt", PKT_BITS'(drop_cnt), PKT_BITS'(exp_drops));
`endif

    // 5: shift edge cases
    cfg_common();
    msk[0] = 32'hFFFF_FFFF; sft[0] = 6'd31; msk[1] = 32'h0;
    send_evt(32'h8000_0000, 0);
    send_evt(32'hFFFF_FFFF, 0);
    idle();
    msk[0] = 32'hFFFF_FFFF; sft[0] = 6'h20;  // -32
    send_evt(32'hFFFF_FFFF, 0);
    send_evt(32'h1234_5678, 0);
    drain();

    // 6: reset with a pending packet
    cfg_common();
    send_evt(32'h0012_0034, 2);
    @(posedge clk_tb); #1;
    evt_vld  = 1'b0;
    reset_tb = 1'b1;
    @(negedge clk_tb); #1;
    exp_q.delete();
    exp_drops = 0;
    @(posedge clk_tb); #1;
    reset_tb = 1'b0;
    @(negedge clk_tb); #1;
    chk("rst6_vld", PKT_BITS'(pkt_vld), '0);
    chk("rst6_data", pkt_data, '0);
    for (int n = 0; n < 8; n++) send_evt(32'h0001_0000 * 32'(n) + 32'(n), 0);
    drain();
`ifdef PKT_ASM_DROP_CNT_EN
    chk("drop_cnt_rst", PKT_BITS'(drop_cnt), PKT_BITS'(exp_drops));
`endif

    // 7: random configurations and events
    for (int r = 0; r < 6; r++) begin
      idle();
      key = $urandom();
      for (int i = 0; i < int'(NM); i++) begin
        msk[i] = $urandom();
        sft[i] = 6'($urandom_range(0, 63));
        lmt[i] = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom();
      end
      for (int n = 0; n < 30; n++) send_evt($urandom(), 1);
    end
    drain();
`ifdef PKT_ASM_DROP_CNT_EN
    chk("drop_cnt_rand", PKT_BITS'(drop_cnt), PKT_BITS'(exp_drops));
`endif

    repeat (2) @(posedge clk_tb);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
